resolution_overlay: RTL
=======================

// Module: resolution_overlay
// PURPOSE
//  Consumer stage of the resolution char ROM: fetches one RESLINE_SIZE-bit glyph row per video line
//  and serializes it MSB-first onto the pixel stream at a fixed screen window.
//  Lit bits replace the incoming pixel with FG_COLOR; all others pass through (or get BG_COLOR if OPAQUE).
//  Sits between the test-pattern generator and the video output register stage.
// PARAMETERS
//  X_POS       64            first pixel column of overlay; must be >= 4
//  Y_POS       32            first video line of overlay
//  LINE_WIDTH  `RESLINE_SIZE bits per ROM row (136)
//  ROWS        16            ROM rows (addr 0..15)
//  SCALE_LOG2  0             pixel/line replication = 2**SCALE_LOG2 (0..2)
//  FG_COLOR    24'hFFFFFF    colour of lit glyph bits
//  BG_COLOR    24'h000000    colour of unlit bits inside window when OPAQUE=1
//  OPAQUE      0             1: unlit window bits drive BG_COLOR; 0: pass rgb_in
// PORTS
//  clock      in   1           pixel clock
//  reset      in   1           synchronous, active-high
//  overlay_en in   1           overlay enable; sampled at hcount==0 only
//  hcount     in   12          current pixel column, 0 at line start
//  vcount     in   12          current line
//  de_in      in   1           data enable
//  hsync_in   in   1           horizontal sync
//  vsync_in   in   1           vertical sync
//  rgb_in     in   24          incoming pixel
//  rom_addr   out  4           row address to resolution ROM
//  rom_q      in   LINE_WIDTH  ROM row data, valid 1 clock after rom_addr changes
//  de_out     out  1           de_in delayed 1 clock
//  hsync_out  out  1           hsync_in delayed 1 clock
//  vsync_out  out  1           vsync_in delayed 1 clock
//  rgb_out    out  24          composited pixel, 1 clock latency
// BEHAVIOUR
//  Reset: state=IDLE, rom_addr=0, row_active=0, shift_reg=0; all outputs 0. Reset mid-line aborts any row.
//  Window vertical: Y_POS <= vcount < Y_POS + ROWS<<SCALE_LOG2 (12-bit unsigned compare, no wrap).
//  Line start (hcount==0):
//    - row_active <= overlay_en & in vertical window.
//    - If set: rom_addr <= (vcount-Y_POS)>>SCALE_LOG2; else rom_addr holds.
//    - State forced to IDLE regardless of prior state (a row unfinished at line wrap is truncated).
//  rom_q is valid from hcount==2 onward.
//  FSM states:
//    IDLE  -> ARMED when hcount==0 & row_active(next) true
//    ARMED -> SHIFT at hcount==X_POS-1: shift_reg<=rom_q, bit_cnt<=LINE_WIDTH-1, sub_cnt<=0
//    SHIFT: pix_bit=shift_reg[MSB]; sub_cnt++ each clock
//           when sub_cnt==2**SCALE_LOG2-1: sub_cnt<=0, shift left 1, bit_cnt--
//           -> DONE after bit 0 consumed (LINE_WIDTH<<SCALE_LOG2 clocks in SHIFT)
//    DONE  -> IDLE at next hcount==0
//  Overlay pixel columns: X_POS .. X_POS+(LINE_WIDTH<<SCALE_LOG2)-1; first column shows rom_q MSB.
//  Output register (every clock):
//    - in SHIFT & pix_bit            : rgb_out<=FG_COLOR
//    - in SHIFT & !pix_bit & OPAQUE  : rgb_out<=BG_COLOR
//    - otherwise                     : rgb_out<=rgb_in
//    - de/hsync/vsync_out <= inputs.
//  de_in does not gate the FSM; compositing is applied regardless, so blanking pixels follow rgb_in.
//  overlay_en or vcount changes mid-line take effect only at the next hcount==0.
//  bit_cnt width = $clog2(LINE_WIDTH); sub_cnt 2 bits; no other arithmetic overflow possible.
// STRUCTURE
//  defines.v: RESLINE_SIZE (existing), OVL_STATE typedef {IDLE,ARMED,SHIFT,DONE}, OVL_FG/BG colour defaults.
//  Single module; no sub-module (shifter+FSM too small to split).
// TESTING
//  Bench uses behavioural 1-clock ROM; X_POS=16, Y_POS=8, SCALE_LOG2=0, OPAQUE=0, rgb_in=24'h123456.
//  1 reset held 3 clks mid-line at vcount=9 -> all outputs 0; following line with hcount=20 passes rgb_in
//    (state IDLE until next hcount==0).
//  2 vcount=8, row0 = MSB 1 then 0s -> rom_addr=0; rgb_out=FFFFFF for hcount=16 only, seen 1 clk later;
//    hcount=17..151 pass 123456.
//  3 vcount=23 (row 15) then 24 -> rom_addr=15 on line 23; line 24 no overlay, rom_addr stays 15.
//  4 SCALE_LOG2=1, vcount=10, row all ones -> rom_addr=1; FFFFFF on hcount=16..287 (272 px).
//  5 overlay_en dropped at hcount=50 of active line -> row completes;
//    next line (hcount==0 en=0) no overlay.
//  6 hcount wraps to 0 at 100 while in SHIFT -> pixels 16..99 drawn;
//    next line restarts at MSB; OPAQUE=1 run checks unlit bits = BG_COLOR.

Source files
------------

// File: rtl/resolution_overlay_pkg.sv
// resolution_overlay_pkg: shared widths, colour defaults and FSM state type for the resolution overlay.
package resolution_overlay_pkg;
   localparam int          RESLINE_SIZE = 136;
   localparam logic [23:0] OVL_FG       = 24'hFFFFFF;
   localparam logic [23:0] OVL_BG       = 24'h000000;
   typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} ovl_state_e;
endpackage

// File: rtl/resolution_overlay.sv
// resolution_overlay: fetches one glyph row per video line and serializes it MSB-first
// onto the pixel stream inside a fixed screen window, with one clock of latency.
module resolution_overlay
   import resolution_overlay_pkg::*;
#(
   parameter int          X_POS      = 64,
   parameter int          Y_POS      = 32,
   parameter int          LINE_WIDTH = RESLINE_SIZE,
   parameter int          ROWS       = 16,
   parameter int          SCALE_LOG2 = 0,
   parameter logic [23:0] FG_COLOR   = OVL_FG,
   parameter logic [23:0] BG_COLOR   = OVL_BG,
   parameter bit          OPAQUE     = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  overlay_en,
   input  logic [11:0]           hcount,
   input  logic [11:0]           vcount,
   input  logic                  de_in,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic [23:0]           rgb_in,
   output logic [3:0]            rom_addr,
   input  logic [LINE_WIDTH-1:0] rom_q,
   output logic                  de_out,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic [23:0]           rgb_out
);
   localparam int         BW      = $clog2(LINE_WIDTH);
   localparam int         Y_END   = Y_POS + (ROWS << SCALE_LOG2);
   localparam logic [1:0] SUB_MAX = 2'((1 << SCALE_LOG2) - 1);
   ovl_state_e            state_q;
   logic                  row_active_q, row_active_d;
   logic [3:0]            rom_addr_q, rom_addr_d;
   logic [LINE_WIDTH-1:0] shift_q;
   logic [BW-1:0]         bit_cnt_q;
   logic [1:0]            sub_cnt_q;
   logic [23:0]           rgb_q, rgb_d;
   logic                  de_q, hsync_q, vsync_q;
   logic [11:0]           vrel;
   logic                  line_start, drawing;
   always_comb begin
      line_start   = hcount == 12'd0;
      vrel         = vcount - 12'(Y_POS);
      row_active_d = overlay_en && vcount >= 12'(Y_POS) && {1'b0, vcount} < 13'(Y_END);
      rom_addr_d   = vrel[SCALE_LOG2 +: 4];
      // column 0 is never an overlay column, so a row truncated by line wrap stops drawing there
      drawing      = state_q == SHIFT && !line_start;
      rgb_d        = !drawing ? rgb_in : shift_q[LINE_WIDTH-1] ? FG_COLOR : OPAQUE ? BG_COLOR : rgb_in;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         row_active_q <= 1'b0;
         rom_addr_q   <= '0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         sub_cnt_q    <= '0;
         rgb_q        <= '0;
         de_q         <= 1'b0;
         hsync_q      <= 1'b0;
         vsync_q      <= 1'b0;
      end else begin
         rgb_q   <= rgb_d;
         de_q    <= de_in;
         hsync_q <= hsync_in;
         vsync_q <= vsync_in;
         if (line_start) begin
            row_active_q <= row_active_d;
            if (row_active_d) rom_addr_q <= rom_addr_d;
            state_q <= row_active_d ? ARMED : IDLE;
         end else begin
            case (state_q)
               ARMED: if (row_active_q && hcount == 12'(X_POS - 1)) begin
                  shift_q   <= rom_q;
                  bit_cnt_q <= BW'(LINE_WIDTH - 1);
                  sub_cnt_q <= '0;
                  state_q   <= SHIFT;
               end
               SHIFT: begin
                  sub_cnt_q <= sub_cnt_q + 2'd1;
                  if (sub_cnt_q == SUB_MAX) begin
                     sub_cnt_q <= '0;
                     shift_q   <= shift_q << 1;
                     bit_cnt_q <= bit_cnt_q - 1'b1;
                     if (bit_cnt_q == '0) state_q <= DONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end
   assign rom_addr  = rom_addr_q;
   assign rgb_out   = rgb_q;
   assign de_out    = de_q;
   assign hsync_out = hsync_q;
   assign vsync_out = vsync_q;
endmodule
